// File: rtl/cpu_sequencer_pkg.sv
// Shared state encoding, timer width and default timing values for the
// multi-cycle CPU sequencer and anything that needs to decode its state.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5,
    ST_FAULT     = 3'd6
  } state_e;

  localparam int unsigned TIMER_W           = 4;
  localparam int unsigned DEF_EXEC_CYCLES   = 1;
  localparam int unsigned DEF_FETCH_TIMEOUT = 16;

  // A dwell of N cycles on a down-counter that stops at zero needs N-1 preloaded.
  function automatic logic [TIMER_W-1:0] timer_preload(input int unsigned cycles);
    logic [TIMER_W-1:0] val;
    if (cycles == 0) begin
      val = '0;
    end else begin
      val = TIMER_W'(cycles - 1);
    end
    return val;
  endfunction

endpackage

// File: rtl/cpu_sequencer_timer.sv
// 4-bit loadable down-counter with zero flag, shared by the fetch timeout
// and the execute dwell; it holds at zero instead of wrapping.
module seq_timer
  import cpu_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXECUTE -> WRITEBACK with
// per-phase enables, memory handshake, fetch timeout and retire counter.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES   = DEF_EXEC_CYCLES,
  parameter int unsigned FETCH_TIMEOUT = DEF_FETCH_TIMEOUT,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic             ir_load,
  output logic             pc_inc,
  input  logic             dec_reg_wr,
  input  logic             halt_inst,
  output logic             reg_wr_en,
  output logic [2:0]       state,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam logic [TIMER_W-1:0] EXEC_LOAD  = timer_preload(EXEC_CYCLES);
  localparam logic [TIMER_W-1:0] FETCH_LOAD = timer_preload(FETCH_TIMEOUT);
  localparam bit                 TIMEOUT_EN = (FETCH_TIMEOUT != 0);

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   retired_q;
  logic [CNT_W-1:0]   retired_d;
  logic               t_load;
  logic               t_dec;
  logic [TIMER_W-1:0] t_val;
  logic               t_zero;

  seq_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Timer is preloaded on entry to FETCH and EXECUTE; an ack in the last
  // allowed fetch cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    t_load  = 1'b0;
    t_val   = '0;
    t_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
          t_load  = 1'b1;
          t_val   = FETCH_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (mem_ack) begin
          state_d = ST_DECODE;
        end else if (TIMEOUT_EN && t_zero) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_FETCH;
          t_dec   = 1'b1;
        end
      end
      ST_DECODE: begin
        if (halt_inst) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXECUTE;
          t_load  = 1'b1;
          t_val   = EXEC_LOAD;
        end
      end
      ST_EXECUTE: begin
        if (t_zero) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_EXECUTE;
          t_dec   = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        if (run) begin
          state_d = ST_FETCH;
          t_load  = 1'b1;
          t_val   = FETCH_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (run) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    reg_wr_en = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    retired_d = retired_q;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ack;
        busy    = 1'b1;
      end
      ST_DECODE:  busy = 1'b1;
      ST_EXECUTE: busy = 1'b1;
      ST_WRITEBACK: begin
        busy      = 1'b1;
        pc_inc    = 1'b1;
        reg_wr_en = dec_reg_wr;
        retired_d = retired_q + CNT_W'(1);
      end
      ST_HALT:  halted = 1'b1;
      ST_FAULT: fault  = 1'b1;
      default:  busy   = 1'b0;
    endcase
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule
